divider_recombine: RTL and testbench



---
 rtl/divider_recombine.sv | 94 +++++++++
 tb/tb_divider_recombine.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/divider_recombine.sv
// divider_recombine: rebuilds dividend = quotient*divisor + remainder with a
// serial shift-add, one quotient bit per cycle, MSB first.
module divider_recombine #(
    parameter int N = 6,
    parameter int M = 4
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   quotient,
    input  logic [M-1:0]   divisor,
    input  logic [M-1:0]   remainder,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N+M-1:0] dividend,
    output logic           rem_err,
    output logic           busy
);
    localparam int W  = N + M;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state, state_nxt;
    logic [N-1:0]  q_r;
    logic [M-1:0]  d_r, r_r;
    logic [W-1:0]  acc, sum;
    logic [CW-1:0] cnt;
    logic          last;

    // q_r is shifted left each step, so its MSB is always the current quotient bit
    assign last = (cnt == CW'(N - 1));

    // One shift-add step; the remainder is folded in on the final step
    always_comb begin
        sum = {acc[W-2:0], 1'b0};
        if (q_r[N-1]) sum = sum + W'(d_r);
        if (last)     sum = sum + W'(r_r);
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; DONE never accepts new operands
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = CALC;
            CALC:    if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Operand capture, accumulation and result hold
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q_r      <= '0;
            d_r      <= '0;
            r_r      <= '0;
            acc      <= '0;
            cnt      <= '0;
            dividend <= '0;
            rem_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    q_r     <= quotient;
                    d_r     <= divisor;
                    r_r     <= remainder;
                    acc     <= '0;
                    cnt     <= '0;
                    rem_err <= (remainder >= divisor);
                end
                CALC: begin
                    acc <= sum;
                    q_r <= q_r << 1;
                    cnt <= cnt + CW'(1);
                    if (last) dividend <= sum;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_divider_recombine.sv
// Scoreboard bench for divider_recombine (N=6, M=4).
module tb_divider_recombine;
    localparam int N = 6;
    localparam int M = 4;
    localparam int W = N + M;

    logic         clk = 1'b0;
    logic         rstn;
    logic         in_valid, in_ready;
    logic [N-1:0] quotient;
    logic [M-1:0] divisor, remainder;
    logic         out_valid, out_ready;
    logic [W-1:0] dividend;
    logic         rem_err, busy;

    typedef struct packed {
        logic [W-1:0] div;
        logic         err;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    divider_recombine #(.N(N), .M(M)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready),
        .quotient(quotient), .divisor(divisor), .remainder(remainder),
        .out_valid(out_valid), .out_ready(out_ready),
        .dividend(dividend), .rem_err(rem_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compare each result as it is handed off downstream
    always @(negedge clk) begin
        if (rstn && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("dividend", int'(dividend), int'(e.div));
                chk("rem_err", int'(rem_err), int'(e.err));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Handshake one operand set and record its expected result
    task automatic accept(input int q, input int d, input int r, input int ed, input bit ee);
        int g;
        g = 0;
        while (!in_ready && g < 50) begin tick(); g++; end
        if (!in_ready) chk("accept_timeout", 0, 1);
        quotient  = N'(q);
        divisor   = M'(d);
        remainder = M'(r);
        in_valid  = 1'b1;
        tick();
        sb.push_back('{div: W'(ed), err: ee});
        in_valid  = 1'b0;
        // operands are latched; scramble the ports during CALC
        quotient  = ~N'(q);
        divisor   = ~M'(d);
        remainder = ~M'(r);
    endtask

    // Count edges from accept until out_valid
    task automatic wait_out(input int exp_lat);
        int k;
        for (k = 1; k <= 30; k++) begin
            tick();
            if (out_valid) break;
        end
        chk("latency", k, exp_lat);
    endtask

    task automatic op(input int q, input int d, input int r, input int ed, input bit ee);
        accept(q, d, r, ed, ee);
        wait_out(N);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        quotient = '0; divisor = '0; remainder = '0;
        #12;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_dividend", int'(dividend), 0);
        chk("rst_rem_err", int'(rem_err), 0);
        rstn = 1'b1;
        tick();

        // directed vectors
        op(45, 7, 3, 318, 1'b0);
        op(63, 15, 15, 960, 1'b1);
        op(63, 15, 14, 959, 1'b0);
        op(0, 0, 5, 5, 1'b1);
        op(1, 1, 0, 1, 1'b0);

        // backpressure in DONE
        out_ready = 1'b0;
        accept(45, 7, 3, 318, 1'b0);
        wait_out(N);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                in_valid = 1'b1; quotient = 6'd63; divisor = 4'd1; remainder = 4'd0;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            chk("bp_out_valid", int'(out_valid), 1);
            chk("bp_dividend", int'(dividend), 318);
            chk("bp_rem_err", int'(rem_err), 0);
            chk("bp_in_ready", int'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_idle_in_ready", int'(in_ready), 1);
        chk("bp_idle_busy", int'(busy), 0);
        tick(); tick();
        chk("bp_pulse_ignored", int'(busy), 0);

        // reset during CALC
        accept(45, 7, 3, 318, 1'b0);
        tick(); tick(); tick();
        rstn = 1'b0;
        void'(sb.pop_back());
        #1;
        chk("abort_in_ready", int'(in_ready), 1);
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_dividend", int'(dividend), 0);
        chk("abort_rem_err", int'(rem_err), 0);
        #3;
        rstn = 1'b1;
        tick();
        op(10, 9, 8, 98, 1'b0);

        // back-to-back with in_valid held high
        begin
            int last_acc, g, q, d, r;
            last_acc = 0;
            for (int i = 0; i < 1000; i++) begin
                q = int'($urandom_range(63));
                d = int'($urandom_range(15));
                r = int'($urandom_range(15));
                quotient = N'(q); divisor = M'(d); remainder = M'(r);
                in_valid = 1'b1;
                g = 0;
                while (!in_ready && g < 50) begin tick(); g++; end
                if (!in_ready) chk("b2b_timeout", 0, 1);
                tick();
                sb.push_back('{div: W'(q * d + r), err: (r >= d)});
                if (i > 0) chk("issue_interval", cyc - last_acc, N + 2);
                last_acc = cyc;
            end
            in_valid = 1'b0;
        end
        repeat (3 * (N + 2)) tick();
        chk("scoreboard_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
